mem_stage_ctrl: RTL and testbench

//  Consumer end of the EX/MEM pipeline register: drives data-memory accesses and handles call/ret stack traffic.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/memwb_reg.sv | 44 ++++
 rtl/mem_stage_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, register index width
// and the default stack-pointer reset value.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int REG_IDX_W = 5;
  localparam logic [31:0] STACK_TOP_DEFAULT = 32'hFFFF;

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register. A bubble clears every field so writeback sees a no-op.
import cpu_pkg::*;

module memwb_reg #(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bubble,
  input  logic                 reg_write,
  input  logic                 mem_to_reg,
  input  logic [REG_IDX_W-1:0] dest_reg,
  input  logic [DW-1:0]        mem_data,
  input  logic [DW-1:0]        alu_data,
  output logic                 wb_reg_write,
  output logic                 wb_mem_to_reg,
  output logic [REG_IDX_W-1:0] wb_dest_reg,
  output logic [DW-1:0]        wb_mem_data,
  output logic [DW-1:0]        wb_alu_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_dest_reg   <= '0;
      wb_mem_data   <= '0;
      wb_alu_data   <= '0;
    end else if (bubble) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_dest_reg   <= '0;
      wb_mem_data   <= '0;
      wb_alu_data   <= '0;
    end else begin
      wb_reg_write  <= reg_write;
      wb_mem_to_reg <= mem_to_reg;
      wb_dest_reg   <= dest_reg;
      wb_mem_data   <= mem_data;
      wb_alu_data   <= alu_data;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: req/ack data-memory handshake, call/ret stack pointer, upstream stall.
// Optional ack-wait timeout with sticky fault flag is enabled by defining MEM_TIMEOUT_EN.
import cpu_pkg::*;

module mem_stage_ctrl #(
  parameter int             AW        = 32,
  parameter int             DW        = 32,
  parameter logic [AW-1:0]  STACK_TOP = AW'(STACK_TOP_DEFAULT),
  parameter int             TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWrite_in,
  input  logic                 MemWrite_in,
  input  logic                 MemRead_in,
  input  logic                 MemToReg_in,
  input  logic                 MemSrc_in,
  input  logic                 call_in,
  input  logic                 ret_in,
  input  logic [REG_IDX_W-1:0] DestReg_in,
  input  logic [AW-1:0]        ALU_addr_in,
  input  logic [AW-1:0]        NON_ALU_addr_in,
  input  logic [DW-1:0]        MemWrite_data_in,
  output logic                 stall_out,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic                 mem_ack,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 RegWrite_wb,
  output logic                 MemToReg_wb,
  output logic [REG_IDX_W-1:0] DestReg_wb,
  output logic [DW-1:0]        mem_data_wb,
  output logic [DW-1:0]        alu_data_wb,
  output logic                 mem_fault
);

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state, state_next;
  logic [AW-1:0] sp;
  logic          acc, done, stall, bubble, timeout_hit;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wb_mem_data;

  assign acc = MemRead_in | MemWrite_in | call_in | ret_in;

  // call outranks ret, and both outrank the MemSrc-selected address
  always_comb begin
    addr_sel = MemSrc_in ? NON_ALU_addr_in : ALU_addr_in;
    if (call_in)
      addr_sel = sp - ONE;
    else if (ret_in)
      addr_sel = sp;
  end

  always_comb begin
    state_next  = state;
    stall       = 1'b0;
    bubble      = 1'b0;
    done        = 1'b0;
    wb_mem_data = '0;
    case (state)
      IDLE: begin
        if (acc) begin
          stall      = 1'b1;
          bubble     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        done = mem_ack | timeout_hit;
        if (done) begin
          state_next  = IDLE;
          wb_mem_data = mem_ack ? mem_rdata : '0;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset must silence the stall even though it is combinational
  assign stall_out = stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sp        <= STACK_TOP;
    end else begin
      state <= state_next;
      if (state == IDLE && acc) begin
        mem_req   <= 1'b1;
        mem_we    <= call_in | MemWrite_in;
        mem_addr  <= addr_sel;
        mem_wdata <= MemWrite_data_in;
      end else if (state == WAIT && done) begin
        mem_req <= 1'b0;
        if (call_in)
          sp <= sp - ONE;
        else if (ret_in)
          sp <= sp + ONE;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt;
  logic        fault;

  assign timeout_hit = (state == WAIT) && (wait_cnt == TO_LAST) && !mem_ack;
  assign mem_fault   = fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      if (state == IDLE)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 16'd1;
      if (timeout_hit)
        fault <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_fault   = 1'b0;
`endif

  memwb_reg #(.DW(DW)) u_memwb (
    .clk           (clk),
    .rst           (rst),
    .bubble        (bubble),
    .reg_write     (RegWrite_in),
    .mem_to_reg    (MemToReg_in),
    .dest_reg      (DestReg_in),
    .mem_data      (wb_mem_data),
    .alu_data      (ALU_addr_in),
    .wb_reg_write  (RegWrite_wb),
    .wb_mem_to_reg (MemToReg_wb),
    .wb_dest_reg   (DestReg_wb),
    .wb_mem_data   (mem_data_wb),
    .wb_alu_data   (alu_data_wb)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed-vector bench for mem_stage_ctrl; the bench plays the EX/MEM stage and data memory.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in;
  logic        call_in, ret_in;
  logic [4:0]  DestReg_in;
  logic [31:0] ALU_addr_in, NON_ALU_addr_in, MemWrite_data_in;
  logic        stall_out, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        RegWrite_wb, MemToReg_wb;
  logic [4:0]  DestReg_wb;
  logic [31:0] mem_data_wb, alu_data_wb;
  logic        mem_fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_we, seen_req;
  int          stall_cnt;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .MemToReg_in(MemToReg_in), .MemSrc_in(MemSrc_in), .call_in(call_in), .ret_in(ret_in),
    .DestReg_in(DestReg_in), .ALU_addr_in(ALU_addr_in), .NON_ALU_addr_in(NON_ALU_addr_in),
    .MemWrite_data_in(MemWrite_data_in), .stall_out(stall_out), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .RegWrite_wb(RegWrite_wb), .MemToReg_wb(MemToReg_wb),
    .DestReg_wb(DestReg_wb), .mem_data_wb(mem_data_wb), .alu_data_wb(alu_data_wb),
    .mem_fault(mem_fault)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_instr;
    RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0; MemToReg_in = 0; MemSrc_in = 0;
    call_in = 0; ret_in = 0; DestReg_in = 0;
    ALU_addr_in = 0; NON_ALU_addr_in = 0; MemWrite_data_in = 0;
  endtask

  // Instruction is already presented in the IDLE cycle; ack arrives in WAIT cycle waits+1.
  task automatic access(input int waits, input logic [31:0] rdata);
    tick;
    seen_req = mem_req; seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
    repeat (waits) tick;
    mem_ack = 1'b1; mem_rdata = rdata;
    tick;
    mem_ack = 1'b0; mem_rdata = 0;
    clear_instr;
  endtask

  initial begin
    clear_instr;
    mem_ack = 0; mem_rdata = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall_out, 0);
    check("rst_req", mem_req, 0);
    check("rst_regwrite_wb", RegWrite_wb, 0);
    check("rst_fault", mem_fault, 0);
    rst = 1'b0;

    // 1: plain ALU op passes straight through
    tick;
    RegWrite_in = 1; DestReg_in = 5'd3; ALU_addr_in = 32'h55;
    @(negedge clk);
    check("alu_stall", stall_out, 0);
    tick;
    clear_instr;
    check("alu_regwrite_wb", RegWrite_wb, 1);
    check("alu_dest_wb", DestReg_wb, 3);
    check("alu_data_wb", alu_data_wb, 32'h55);

    // 2: load with ack in the 4th WAIT cycle
    RegWrite_in = 1; MemRead_in = 1; MemToReg_in = 1; DestReg_in = 5'd7; ALU_addr_in = 32'h100;
    NON_ALU_addr_in = 32'h999;
    stall_cnt = 0;
    @(negedge clk);
    if (stall_out) stall_cnt++;
    tick;
    check("ld_req", mem_req, 1);
    check("ld_addr", mem_addr, 32'h100);
    check("ld_we", mem_we, 0);
    @(negedge clk);
    if (stall_out) stall_cnt++;
    check("ld_bubble", RegWrite_wb, 0);
    repeat (2) begin
      tick;
      @(negedge clk);
      if (stall_out) stall_cnt++;
    end
    tick;
    mem_ack = 1; mem_rdata = 32'hDEAD;
    @(negedge clk);
    check("ld_stall_on_ack", stall_out, 0);
    tick;
    mem_ack = 0; mem_rdata = 0;
    clear_instr;
    check("ld_stall_cycles", stall_cnt, 4);
    check("ld_mem_data_wb", mem_data_wb, 32'hDEAD);
    check("ld_regwrite_wb", RegWrite_wb, 1);
    check("ld_dest_wb", DestReg_wb, 7);
    check("ld_req_drop", mem_req, 0);

    // 3: call then ret
    call_in = 1; MemWrite_data_in = 32'h40;
    access(0, 32'h0);
    check("call_addr", seen_addr, 32'hFFFE);
    check("call_we", seen_we, 1);
    check("call_wdata", seen_wdata, 32'h40);
    ret_in = 1; RegWrite_in = 1; MemToReg_in = 1; DestReg_in = 5'd9;
    access(1, 32'h40);
    check("ret_addr", seen_addr, 32'hFFFE);
    check("ret_we", seen_we, 0);
    check("ret_data_wb", mem_data_wb, 32'h40);
    // sp back at 0xFFFF: next call writes 0xFFFE again

    // 4: call and ret together act as a call
    call_in = 1; ret_in = 1; MemWrite_data_in = 32'h77;
    access(0, 32'h0);
    check("both_addr", seen_addr, 32'hFFFE);
    check("both_we", seen_we, 1);
    call_in = 1; MemWrite_data_in = 32'h78;
    access(0, 32'h0);
    check("call2_addr", seen_addr, 32'hFFFD);
    mem_ack = 1;
    @(negedge clk);
    check("stray_ack_stall", stall_out, 0);
    tick;
    mem_ack = 0;
    check("stray_ack_req", mem_req, 0);
    ret_in = 1;
    access(0, 32'h1);
    check("stray_ret_addr", seen_addr, 32'hFFFD);

    // 5: asynchronous reset in the middle of a WAIT
    MemRead_in = 1; ALU_addr_in = 32'h200; RegWrite_in = 1;
    tick;
    check("rst_mid_req_before", mem_req, 1);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_stall", stall_out, 0);
    check("rst_mid_addr", mem_addr, 0);
    mem_ack = 1;
    tick;
    mem_ack = 0;
    rst = 1'b0;
    clear_instr;
    tick;
    call_in = 1; MemWrite_data_in = 32'h11;
    access(0, 32'h0);
    check("post_rst_call_addr", seen_addr, 32'hFFFE);
    check("post_rst_call_req", seen_req, 1);

`ifdef MEM_TIMEOUT_EN
    // 6: no ack -> timeout completion after 16 WAIT cycles
    begin
      int waited = 0;
      MemRead_in = 1; MemToReg_in = 1; RegWrite_in = 1; ALU_addr_in = 32'h300;
      tick;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (!stall_out) begin
          waited = i;
          break;
        end
        tick;
      end
      check("to_wait_cycles", waited, 16);
      tick;
      clear_instr;
      check("to_mem_data_wb", mem_data_wb, 0);
      check("to_regwrite_wb", RegWrite_wb, 1);
      check("to_fault", mem_fault, 1);
      repeat (3) tick;
      check("to_fault_sticky", mem_fault, 1);
      rst = 1'b1;
      #1;
      check("to_fault_cleared", mem_fault, 0);
      tick;
      rst = 1'b0;
    end
`else
    check("fault_tied_low", mem_fault, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
